// File: rtl/mdsa_sort_pkg.sv
// Shared constants and types for the 8x8 shearsort matrix sorter.
package mdsa_sort_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned DW        = 32;
  localparam int unsigned MatW      = N * N * DW;
  localparam int unsigned ITER_LAST = 3;

  // Line sort direction as seen by bitonic_sort8.
  localparam logic DirAsc  = 1'b0;
  localparam logic DirDesc = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StFinal,
    StDone
  } state_e;

  // Bit offset of matrix element (r, c) in the row-major 2048-bit word.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c);
    return (r * N + c) * DW;
  endfunction

endpackage

// File: rtl/bitonic_sort8.sv
// Combinational 8-key bitonic sorting network (24 compare-exchange cells).
module bitonic_sort8
  import mdsa_sort_pkg::*;
#(
  parameter int unsigned KeyW = DW
) (
  input  logic              dir_i,
  input  logic [8*KeyW-1:0] data_i,
  output logic [8*KeyW-1:0] data_o
);

  logic [KeyW-1:0] s [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s[i] = data_i[i*KeyW +: KeyW];
    end
    // Merge stage k builds bitonic runs of size k; flipping every cell sorts descending.
    for (int k = 2; k <= 8; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < 8; i++) begin
          if ((i ^ j) > i) begin
            if ((((i & k) == 0) != dir_i) ? (s[3'(i)] > s[3'(i ^ j)])
                                          : (s[3'(i)] < s[3'(i ^ j)])) begin
              {s[3'(i)], s[3'(i ^ j)]} = {s[3'(i ^ j)], s[3'(i)]};
            end
          end
        end
      end
    end
    data_o = '0;
    for (int i = 0; i < 8; i++) begin
      data_o[i*KeyW +: KeyW] = s[i];
    end
  end

endmodule

// File: rtl/mdsa_sort_top.sv
// 64-key shearsort engine: 4 snake row/column iterations, then a final ascending row pass.
module mdsa_sort_top
  import mdsa_sort_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            start_i,
  input  logic [MatW-1:0] data_in_i,
  output logic [MatW-1:0] data_out_o,
  output logic            rdy_o,
  output logic            output_enable_o
);

  state_e          state_q;
  logic [1:0]      it_q;
  logic [MatW-1:0] matrix_q;
  logic [MatW-1:0] sorted_d;
  logic            rdy_q;
  logic            oe_q;

  logic            col_mode;
  logic [N-1:0]    line_dir;
  logic [N*DW-1:0] line_in  [N];
  logic [N*DW-1:0] line_out [N];

  // Sorter r sees row r in row passes and column r in column passes.
  always_comb begin
    col_mode = (state_q == StCol);
    sorted_d = matrix_q;
    for (int r = 0; r < N; r++) begin
      line_dir[r] = (state_q == StRow && (r % 2) == 1) ? DirDesc : DirAsc;
      line_in[r]  = '0;
      for (int c = 0; c < N; c++) begin
        if (col_mode) begin
          line_in[r][c*DW +: DW] = matrix_q[elem_lsb(c, r) +: DW];
        end else begin
          line_in[r][c*DW +: DW] = matrix_q[elem_lsb(r, c) +: DW];
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (col_mode) begin
          sorted_d[elem_lsb(c, r) +: DW] = line_out[r][c*DW +: DW];
        end else begin
          sorted_d[elem_lsb(r, c) +: DW] = line_out[r][c*DW +: DW];
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : gen_line
    bitonic_sort8 #(
      .KeyW (DW)
    ) u_sort (
      .dir_i  (line_dir[g]),
      .data_i (line_in[g]),
      .data_o (line_out[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      it_q     <= '0;
      matrix_q <= '0;
      rdy_q    <= 1'b1;
      oe_q     <= 1'b0;
    end else if (en_i) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            matrix_q <= data_in_i;
            it_q     <= '0;
            state_q  <= StRow;
            rdy_q    <= 1'b0;
            oe_q     <= 1'b0;
          end
        end
        StRow: begin
          matrix_q <= sorted_d;
          state_q  <= StCol;
        end
        StCol: begin
          matrix_q <= sorted_d;
          if (it_q == 2'(ITER_LAST)) begin
            state_q <= StFinal;
          end else begin
            it_q    <= it_q + 2'd1;
            state_q <= StRow;
          end
        end
        StFinal: begin
          matrix_q <= sorted_d;
          state_q  <= StDone;
          rdy_q    <= 1'b1;
          oe_q     <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          rdy_q   <= 1'b1;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o      = matrix_q;
  assign rdy_o           = rdy_q;
  assign output_enable_o = oe_q;

endmodule

// File: tb/tb_mdsa_sort_top.sv
// Scoreboard bench for mdsa_sort_top: expected results come from a plain queue sort of the keys.
module tb_mdsa_sort_top;

  typedef logic [2047:0] word_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  en;
  logic  start;
  word_t data_in;
  word_t data_out;
  logic  rdy;
  logic  oe;

  int    n_chk  = 0;
  int    n_fail = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  mdsa_sort_top dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .en_i            (en),
    .start_i         (start),
    .data_in_i       (data_in),
    .data_out_o      (data_out),
    .rdy_o           (rdy),
    .output_enable_o (oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_word(input string name, input word_t act, input word_t exp);
    int bad = -1;
    n_chk++;
    for (int k = 0; k < 64; k++) begin
      if (bad < 0 && act[32*k +: 32] !== exp[32*k +: 32]) bad = k;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got 0x%08h expected 0x%08h", name, bad,
               act[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  task automatic chk_asc(input word_t w);
    int bad = -1;
    n_chk++;
    for (int k = 0; k < 63; k++) begin
      if (bad < 0 && w[32*k +: 32] > w[32*(k+1) +: 32]) bad = k;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL ascending: element %0d = 0x%08h exceeds element %0d = 0x%08h", bad,
               w[32*bad +: 32], bad + 1, w[32*(bad+1) +: 32]);
    end
  endtask

  function automatic word_t ref_sort(input word_t w);
    logic [31:0] q[$];
    word_t r = '0;
    for (int k = 0; k < 64; k++) q.push_back(w[32*k +: 32]);
    q.sort();
    for (int k = 0; k < 64; k++) r[32*k +: 32] = q[k];
    return r;
  endfunction

  function automatic word_t shuffle(input word_t w);
    word_t r = w;
    logic [31:0] t;
    for (int i = 63; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      t = r[32*i +: 32];
      r[32*i +: 32] = r[32*j +: 32];
      r[32*j +: 32] = t;
    end
    return r;
  endfunction

  // Issue one sort; return once output_enable is seen or the cycle budget runs out.
  task automatic do_sort(input word_t w, input int hold, input int exp_lat, input int stall_at);
    int    edges = 0;
    word_t snap  = '0;
    data_in = w;
    exp_q.push_back(ref_sort(w));
    start = 1'b1;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges >= hold) start = 1'b0;
      if (edges == 1) begin
        chk("busy_rdy", 32'(rdy), 32'd0);
        chk("busy_oe", 32'(oe), 32'd0);
      end
      if (stall_at > 0 && edges == stall_at) begin
        snap = data_out;
        en   = 1'b0;
      end
      if (stall_at > 0 && edges == stall_at + 5) begin
        chk("stall_frozen", 32'(data_out == snap), 32'd1);
        en = 1'b1;
      end
    end while (!oe && edges < 60);
    chk("latency", 32'(edges), 32'(exp_lat));
  endtask

  // Monitor: each rising output_enable consumes one expected result.
  initial begin
    logic  oe_prev = 1'b0;
    word_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        oe_prev = 1'b0;
      end else begin
        if (oe && !oe_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk_word("sorted_result", data_out, e);
            chk_asc(data_out);
          end
        end
        oe_prev = oe;
      end
    end
  end

  initial begin
    word_t w;
    word_t set2;
    rst_n   = 1'b0;
    en      = 1'b1;
    start   = 1'b0;
    data_in = '0;
    #12;
    chk("reset_data_zero", 32'(data_out == '0), 32'd1);
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_oe", 32'(oe), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rdy", 32'(rdy), 32'd1);
    chk("idle_oe", 32'(oe), 32'd0);

    // Set 1: keys 3..534 with duplicated 76, 119, 235; start held 4 cycles.
    w = '0;
    w[0 +: 32]   = 32'd3;
    w[32 +: 32]  = 32'd534;
    w[64 +: 32]  = 32'd76;
    w[96 +: 32]  = 32'd76;
    w[128 +: 32] = 32'd119;
    w[160 +: 32] = 32'd119;
    w[192 +: 32] = 32'd235;
    w[224 +: 32] = 32'd235;
    for (int k = 8; k < 64; k++) w[32*k +: 32] = $urandom_range(3, 534);
    w = shuffle(w);
    do_sort(w, 4, 10, 0);
    chk("set1_min", data_out[31:0], 32'd3);
    chk("set1_max", data_out[2047:2016], 32'd534);

    // Same data with en low for 5 cycles while in COL.
    do_sort(w, 1, 15, 2);

    // Reverse order.
    for (int k = 0; k < 64; k++) w[32*k +: 32] = 32'(63 - k);
    do_sort(w, 1, 10, 0);
    chk("reverse_elem37", data_out[32*37 +: 32], 32'd37);

    // All keys equal.
    for (int k = 0; k < 64; k++) w[32*k +: 32] = 32'h5A5A5A5A;
    do_sort(w, 2, 10, 0);
    chk("equal_elem10", data_out[32*10 +: 32], 32'h5A5A5A5A);

    // Set 2: 63 keys up to 600, element 63 left at 0.
    set2 = '0;
    set2[0 +: 32] = 32'd600;
    for (int k = 1; k < 63; k++) set2[32*k +: 32] = $urandom_range(1, 600);
    set2 = shuffle(set2);
    if (set2[2016 +: 32] != 32'd0) begin
      for (int k = 0; k < 63; k++) begin
        if (set2[32*k +: 32] == 32'd0) set2[32*k +: 32] = set2[2016 +: 32];
      end
      set2[2016 +: 32] = 32'd0;
    end

    // Abort a sort in progress with an asynchronous reset.
    data_in = set2;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_data_zero", 32'(data_out == '0), 32'd1);
    chk("abort_rdy", 32'(rdy), 32'd1);
    chk("abort_oe", 32'(oe), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_sort(set2, 1, 10, 0);
    chk("set2_min", data_out[31:0], 32'd0);
    chk("set2_max", data_out[2047:2016], 32'd600);

    // Full-range random keys; restarts from DONE, start held into ROW.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 64; k++) w[32*k +: 32] = $urandom;
      do_sort(w, int'($urandom_range(1, 5)), 10, 0);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdsa_sort_top.md
# mdsa_sort_top

- Top-level 64-element multidimensional sorter (MDSA).
- Treats a 2048-bit input word as an 8×8 matrix of 32-bit unsigned keys.
- Sorts it with a shearsort schedule: alternating row and column passes, each pass using eight parallel 8-input bitonic networks.
- Returns the keys in ascending order, with element 0 holding the smallest key.
- Sits between a bulk-data source and a consumer; uses a start / rdy / output_enable handshake.

## Interface
- N, 8: matrix dimension (rows = columns = N); only 8 is supported.
- DW, 32: key width in bits.
- clk  in  1  single system clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global clock enable; when low, all state and registers hold.
- start  in  1  request to sort data_in.
- data_in  in  N·N·DW (2048)  element k = data_in[32k+31:32k].
- data_out  out  2048  matrix register; element k = data_out[32k+31:32k].
- rdy  out  1  block can accept start.
- output_enable  out  1  data_out holds a completed sorted result.

## Operation
- Element k maps to row r = k/8, column c = k%8.
- All comparisons are unsigned 32-bit. Ties need no particular ordering.
- Row pass, snake:
  - even rows: ascending with increasing c;
  - odd rows: descending with increasing c.
- Row pass, final: all rows ascending.
- Column pass: all columns ascending with increasing r.
- Each pass is a full combinational 8-key bitonic sort of every line, registered back into the matrix in one cycle.
- FSM states: IDLE, ROW, COL, FINAL, DONE. 2-bit iteration counter it.
- IDLE or DONE with start=1 and en=1:
  - matrix <= data_in;
  - it <= 0;
  - next state ROW.
- ROW: snake row pass; next state COL.
- COL: column pass.
  - If it=3, next state FINAL.
  - Otherwise it <= it+1 and next state ROW.
- FINAL: ascending row pass; next state DONE.
- DONE: hold matrix; next state changes only on a new start.
- start is ignored in ROW, COL and FINAL.
- Outputs:
  - rdy = 1 in IDLE and DONE;
  - output_enable = 1 only in DONE;
  - data_out = matrix register, always.
- Result: row-major ascending order. data_out[31:0] is the minimum key; data_out[2047:2016] is the maximum.

## Timing
- Reset (rst=0, asynchronous):
  - state = IDLE, it = 0, matrix = 0;
  - so data_out = 0, rdy = 1, output_enable = 0.
- Reset mid-sort aborts the sort immediately and returns to the IDLE reset values.
- Latency from the edge that samples start (edge 0):
  - edges 1–8 perform R, C, R, C, R, C, R, C;
  - edge 9 performs FINAL;
  - DONE, output_enable and rdy are high after edge 9.
- rdy is low and output_enable low during edges 1–9.
- en=0 freezes state, it and matrix for any number of cycles. Sorting resumes with an unchanged schedule when en returns high.
- start held high for several cycles:
  - sampled once on entry from IDLE;
  - if still high in DONE, it starts a new sort on the then-current data_in;
  - sources must deassert start within 9 cycles to avoid a restart.
- start in DONE: output_enable drops on the next enabled edge.

## Structure
- Shared package holds:
  - N, DW;
  - the state enum;
  - localparam ITER_LAST = 3;
  - the direction encoding (0 = ascending, 1 = descending).
- Sub-module bitonic_sort8 (DW-parametric):
  - combinational 8-input bitonic network of 24 compare-exchange cells, with a dir input;
  - instantiated 8 times;
  - each instance's input/output is muxed between row r and column r.
- Top holds the FSM, the iteration counter and the 2048-bit matrix register.

## Test plan
- Reset then idle:
  - check data_out = 0, rdy = 1, output_enable = 0 after rst=0.
- Random set 1 (64 keys in 3..534, including duplicates 76, 119, 235):
  - pulse start for 4 cycles;
  - output_enable rises exactly 10 edges after the first start edge;
  - data_out[31:0] = 3, data_out[2047:2016] = 534;
  - every element k ≤ element k+1.
- Reverse order, element k = 63−k:
  - output element k = k;
  - all-equal 0x5A5A5A5A input returns unchanged.
- Set 2 with only 63 specified keys (element 63 = 0, max 600):
  - run after a mid-run rst pulse aborts a sort in progress;
  - result element 0 = 0, element 63 = 600, ascending.
- en dropped low for 5 cycles during COL:
  - matrix and state frozen;
  - output_enable rises 5 cycles later than nominal;
  - result identical to the uninterrupted run.
- start asserted during ROW: ignored; a new start in DONE re-sorts the new data_in.
